// File: rtl/core_control_pkg.sv
// core_control_pkg: shared constants for the multi-cycle RV32I controller.
// Holds the RV32I major opcodes, the controller state encodings, the
// writeback / next-PC source selects and a helper for the watchdog counter
// width.
package core_control_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    // Controller states (visible on the debug state output)
    localparam logic [2:0] STATE_FETCH  = 3'd0;
    localparam logic [2:0] STATE_DECODE = 3'd1;
    localparam logic [2:0] STATE_EXEC   = 3'd2;
    localparam logic [2:0] STATE_MEM    = 3'd3;
    localparam logic [2:0] STATE_WB     = 3'd4;
    localparam logic [2:0] STATE_HALT   = 3'd5;

    // Register-file writeback source
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    // Next-PC source
    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_IMM  = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;

    // Width of a counter that must hold 0..timeout, never narrower than 1 bit.
    function automatic int wait_cnt_width(input int timeout);
        if (timeout < 1) return 1;
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/core_control_if.sv
// core_control_if: instruction and data memory handshakes of the core.
// Handshake rule: a request (imem_req / dmem_req) is held high and stable
// until the matching ready is sampled high on a rising edge; that edge
// completes the transfer, and the request is never re-issued in the cycle
// right after ready. dmem_we qualifies dmem_req (1 = store).
//   master: the controller (drives requests)
//   slave : the memory side (drives readies)
interface core_control_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/core_control_bus_watchdog.sv
// core_control_bus_watchdog: stall counter for one request/ready pair.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clear    - restart the count (a new request phase begins)
//   req      - request currently asserted
//   ready    - matching ready
//   expire   - this cycle is the TIMEOUT-th consecutive stalled cycle
// TIMEOUT = 0 disables the watchdog (expire never asserts).
module core_control_bus_watchdog
    import core_control_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic req,
    input  logic ready,
    output logic expire
);

    localparam int W = wait_cnt_width(TIMEOUT);

    logic [W-1:0] wait_cnt;
    logic         stalled;

    assign stalled = req && !ready;

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
            // wait_cnt holds the number of stalls already seen, so the
            // TIMEOUT-th stall is the one that finds LAST in the counter.
            assign expire = stalled && (wait_cnt == LAST);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear || (req && ready)) begin
            wait_cnt <= '0;
        end else if (stalled && !expire) begin
            wait_cnt <= wait_cnt + W'(1);
        end
    end

endmodule

// File: rtl/core_control.sv
// core_control: multi-cycle sequencing controller for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, drives the
// memory handshakes and the PC / IR / register-file strobes, counts retired
// instructions and halts on ECALL/EBREAK or a memory timeout.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   opcode, funct3      - decoded fields of the current IR
//   is_load/is_store/is_writeback - decoder classification flags
//   branch_taken        - ALU compare result, meaningful in EXEC
//   mem                 - imem/dmem request/ready handshakes (master side)
//   ir_we               - latch the fetched word into IR
//   reg_we, wb_sel      - register write strobe and writeback source
//   pc_we, pc_sel       - PC update strobe and next-PC source
//   halted              - core stopped (left only through rst)
//   bus_err             - sticky: a memory request timed out
//   retired             - retired-instruction count, wraps at 2^CNT_W
//   state               - current controller state, for debug
module core_control
    import core_control_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              is_writeback,
    input  logic              branch_taken,
    core_control_if.master    mem,
    output logic              ir_we,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              halted,
    output logic              bus_err,
    output logic [CNT_W-1:0]  retired,
    output logic [2:0]        state
);

    logic [2:0]       state_q;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] retired_q;
    logic             bus_err_q;

    logic       imem_req_c;
    logic       ir_we_c;
    logic       dmem_req_c;
    logic       dmem_we_c;
    logic       reg_we_c;
    logic [1:0] wb_sel_c;
    logic       pc_we_c;
    logic [1:0] pc_sel_c;
    logic       halted_c;
    logic       set_err;

    logic wd_req;
    logic wd_ready;
    logic wd_clear;
    logic wd_expire;
    logic halt_entry;

    logic is_halt_op;
    logic is_jal;
    logic is_jalr;

    assign is_halt_op = (opcode == OPCODE_SYSTEM) && (funct3 == 3'b000);
    assign is_jal     = (opcode == OPCODE_JAL);
    assign is_jalr    = (opcode == OPCODE_JALR);

    always_comb begin
        next_state = state_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        reg_we_c   = 1'b0;
        wb_sel_c   = WB_SEL_ALU;
        pc_we_c    = 1'b0;
        pc_sel_c   = PC_SEL_PC4;
        halted_c   = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            STATE_FETCH: begin
                imem_req_c = 1'b1;
                // ready beats the watchdog: expire already requires !ready
                if (mem.imem_ready) begin
                    ir_we_c    = 1'b1;
                    next_state = STATE_DECODE;
                end else if (wd_expire) begin
                    set_err    = 1'b1;
                    next_state = STATE_HALT;
                end
            end
            STATE_DECODE: begin
                next_state = STATE_EXEC;
            end
            STATE_EXEC: begin
                if (is_load || is_store) begin
                    next_state = STATE_MEM;
                end else if (is_halt_op) begin
                    next_state = STATE_HALT;
                end else if (is_writeback) begin
                    next_state = STATE_WB;
                end else begin
                    // branches and everything unrecognised retire here
                    pc_we_c = 1'b1;
                    if ((opcode == OPCODE_BRANCH) && branch_taken) begin
                        pc_sel_c = PC_SEL_IMM;
                    end
                    next_state = STATE_FETCH;
                end
            end
            STATE_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                if (mem.dmem_ready) begin
                    if (is_store) begin
                        pc_we_c    = 1'b1;
                        next_state = STATE_FETCH;
                    end else begin
                        next_state = STATE_WB;
                    end
                end else if (wd_expire) begin
                    set_err    = 1'b1;
                    next_state = STATE_HALT;
                end
            end
            STATE_WB: begin
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                if (is_load) begin
                    wb_sel_c = WB_SEL_LOAD;
                end else if (is_jal || is_jalr) begin
                    wb_sel_c = WB_SEL_PC4;
                end
                if (is_jal) begin
                    pc_sel_c = PC_SEL_IMM;
                end else if (is_jalr) begin
                    pc_sel_c = PC_SEL_JALR;
                end
                next_state = STATE_FETCH;
            end
            STATE_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                next_state = STATE_FETCH;
            end
        endcase
    end

    // One watchdog serves both buses; only one request can be live at a time.
    assign wd_req   = (state_q == STATE_FETCH) ? imem_req_c : dmem_req_c;
    assign wd_ready = (state_q == STATE_FETCH) ? mem.imem_ready :
                      (state_q == STATE_MEM)   ? mem.dmem_ready : 1'b0;
    assign wd_clear = (next_state != state_q) &&
                      ((next_state == STATE_FETCH) || (next_state == STATE_MEM));

    core_control_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .req    (wd_req),
        .ready  (wd_ready),
        .expire (wd_expire)
    );

    // Every HALT entry counts once, whether from ECALL/EBREAK or a timeout.
    assign halt_entry = (next_state == STATE_HALT) && (state_q != STATE_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STATE_FETCH;
            retired_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (pc_we_c || halt_entry) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (set_err) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // rst forces every output low in the same cycle, even before the
    // registered state has been reset.
    assign mem.imem_req = imem_req_c & ~rst;
    assign mem.dmem_req = dmem_req_c & ~rst;
    assign mem.dmem_we  = dmem_we_c  & ~rst;
    assign ir_we        = ir_we_c    & ~rst;
    assign reg_we       = reg_we_c   & ~rst;
    assign wb_sel       = rst ? WB_SEL_ALU : wb_sel_c;
    assign pc_we        = pc_we_c    & ~rst;
    assign pc_sel       = rst ? PC_SEL_PC4 : pc_sel_c;
    assign halted       = halted_c   & ~rst;
    assign bus_err      = bus_err_q  & ~rst;
    assign retired      = rst ? '0 : retired_q;
    assign state        = rst ? STATE_FETCH : state_q;

endmodule

// File: doc/core_control.md
# core_control

Multi-cycle sequencing controller for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, using the decoder's classification flags (is_load, is_store, is_writeback, opcode, funct3). It drives the instruction/data memory handshakes and the PC, IR and register-file write strobes. It also keeps a retired-instruction counter and halts the core on ECALL/EBREAK or a memory timeout.

## Interface
- TIMEOUT, 255: consecutive stalled request cycles before a bus error; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.

- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  7  decoded opcode of the current IR.
- funct3  in  3  decoded funct3 of the current IR.
- is_load / is_store / is_writeback  in  1 each  decoder classification flags.
- branch_taken  in  1  ALU compare result, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid or handshake complete.
- ir_we  out  1  latch fetched word into IR.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data access is a store.
- dmem_ready  in  1  data access complete.
- reg_we  out  1  register-file write strobe.
- wb_sel  out  2  writeback source: 00 = ALU, 01 = load data, 10 = PC+4.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  next-PC source: 00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1.
- halted  out  1  core stopped.
- bus_err  out  1  sticky; set when a memory request timed out.
- retired  out  CNT_W  count of retired instructions.
- state  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: imem_req=1 is held until imem_ready. On the ready cycle, ir_we=1 and next state is DECODE.
- DECODE: one cycle for register read and immediate generation. Always goes to EXEC.
- EXEC, one cycle, resolved in priority order:
  - is_load or is_store → MEM.
  - OPCODE_SYSTEM with funct3==0 → HALT; retired increments and the PC is not written.
  - is_writeback → WB.
  - OPCODE_BRANCH: pc_we=1, pc_sel=01 if branch_taken else 00, then FETCH.
  - Any other opcode (MISC_MEM, CSR, unknown) is a NOP: pc_we=1, pc_sel=00, then FETCH.
- MEM: dmem_req=1 and dmem_we=is_store, held until dmem_ready.
  - Store: on ready, pc_we=1, pc_sel=00, then FETCH.
  - Load: on ready, go to WB.
- WB: reg_we=1 and pc_we=1 in the same cycle, then FETCH.
  - wb_sel: load → 01; JAL/JALR → 10; otherwise 00.
  - pc_sel: JAL → 01; JALR → 10; otherwise 00.
- retired increments once in every cycle where pc_we=1, plus once on HALT entry. It wraps modulo 2^CNT_W.
- Watchdog:
  - wait_cnt counts consecutive cycles with a request high and its ready low. It clears on every completed handshake and on entry to FETCH/MEM.
  - On the TIMEOUT-th such cycle: bus_err←1, next state HALT, request dropped.
  - Ready arriving in that same cycle wins, and the handshake completes normally.
- HALT: all strobes 0 and halted=1. Exit is by rst only.

## Timing
- Outputs are decoded from state. ir_we, and pc_we in MEM, are also gated by the same-cycle ready.
- While rst is high, every output is 0: strobes, halted, bus_err, retired, and state=FETCH. imem_req rises in the first cycle after rst falls.
- Zero-wait latency, from FETCH to the next FETCH:
  - OP/OP_IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/NOP: 3 cycles.
- Each memory wait cycle adds 1.
- Requests stay asserted and stable until ready. A request is never re-issued in the cycle after ready.
- rst mid-request (any state) returns to FETCH next cycle. An aborted request is permitted.
- TIMEOUT=0: the watchdog never fires. wait_cnt width is $clog2(TIMEOUT+1), minimum 1.

## Structure
- Shared defines header, next to the existing OPCODE_*/TYPE_* macros: STATE_*, WB_SEL_*, PC_SEL_*.
- One sub-module, bus_watchdog: counter, TIMEOUT compare and expire output. It is instantiated once, with a single req/ready pair muxed by state.

## Test plan
- ADD (OPCODE_OP), zero-wait memory → states 0,1,2,4,0; reg_we=1 and pc_we=1 only in WB; wb_sel=00; retired 0→1.
- Load with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0; WB with wb_sel=01; 8 cycles total.
- Branch with branch_taken=1 and then 0 → pc_we in EXEC with pc_sel=01, then 00; reg_we never asserted; 3 cycles each.
- TIMEOUT=4, imem_ready held low → bus_err=1 and halted=1 after the 4th stalled cycle.
- Same setup, with ready rising on the 4th stalled cycle → bus_err stays 0 and the fetch completes.
- ECALL (0x00000073) → HALT, retired+1, PC not written.
- rst pulsed in MEM → state 0 and all outputs 0 the next cycle.
- CNT_W=4 with 16 retirements → retired wraps to 0.
